lo_phase_sync_ctrl: RTL and testbench

- Controller for the quadrature LO generator, clocked on REF.
- Configures the LO divider ratio and lets it settle, then reads the REF-sampled LO quadrant (LO_STATE).
- Issues quarter-period phase-slip requests until the sampled quadrant matches a programmed target. After that it holds LOCK and watches for loss of alignment.
- Sits between the PLL/sequencer top level and the LO generator plus its slip logic.

---
 rtl/lo_phase_sync_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lo_phase_sync_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lo_phase_sync_ctrl.sv
// Quadrature LO phase-sync controller: programs the divider, measures the sampled
// LO quadrant and issues quarter-period slips until it matches the target, then tracks lock.
module lo_phase_sync_ctrl #(
  parameter int SETTLE   = 8,
  parameter int NCONS    = 4,
  parameter int MEAS_TO  = 16,
  parameter int MAX_TRY  = 7,
  parameter int SLIP_GAP = 2,
  parameter int LOSS_CNT = 3
) (
  input  logic       REF,
  input  logic       NRST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [2:0] DIV_CFG,
  input  logic [1:0] TGT_STATE,
  input  logic       AUTO_RELOCK,
  input  logic [1:0] LO_STATE,
  output logic [2:0] LO_DIV,
  output logic       SLIP,
  output logic       BUSY,
  output logic       LOCK,
  output logic       FAIL,
  output logic [2:0] TRY_CNT,
  output logic [1:0] MEAS_STATE
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEAS, S_SLIP, S_LOCKED, S_FAILED
  } state_t;

  localparam logic [7:0] SETTLE_END = 8'(SETTLE - 1);
  localparam logic [7:0] MEAS_END   = 8'(MEAS_TO - 1);
  localparam logic [7:0] GAP_END    = 8'(SLIP_GAP);
  localparam logic [3:0] NCONS_L    = 4'(NCONS);
  localparam logic [3:0] LOSS_END   = 4'(LOSS_CNT - 1);
  localparam logic [2:0] MAX_TRY_L  = 3'(MAX_TRY);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] run, run_nxt, run_inc;
  logic [3:0] loss, loss_nxt;
  logic [1:0] rem, rem_nxt;
  logic [2:0] lo_div_q, div_nxt;
  logic [2:0] try_q, try_nxt;
  logic [1:0] meas_q, meas_nxt;
  logic [1:0] tgt_q, prev;
  logic [1:0] slips;
  logic       capture;

  // Position in the LO advance sequence: 10 -> 0, 11 -> 1, 01 -> 2, 00 -> 3.
  function automatic logic [1:0] quad_idx(input logic [1:0] q);
    case (q)
      2'b10:   quad_idx = 2'd0;
      2'b11:   quad_idx = 2'd1;
      2'b01:   quad_idx = 2'd2;
      default: quad_idx = 2'd3;
    endcase
  endfunction

  always_ff @(posedge REF or negedge NRST) begin
    if (!NRST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run      <= '0;
      loss     <= '0;
      rem      <= '0;
      lo_div_q <= '0;
      try_q    <= '0;
      meas_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      run      <= run_nxt;
      loss     <= loss_nxt;
      rem      <= rem_nxt;
      lo_div_q <= div_nxt;
      try_q    <= try_nxt;
      meas_q   <= meas_nxt;
    end
  end

  // Sample history and captured target are only consumed after they are written.
  always_ff @(posedge REF) begin
    prev <= LO_STATE;
    if (capture) tgt_q <= TGT_STATE;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run_nxt   = run;
    loss_nxt  = loss;
    rem_nxt   = rem;
    div_nxt   = lo_div_q;
    try_nxt   = try_q;
    meas_nxt  = meas_q;
    capture   = 1'b0;
    run_inc   = (run == 4'd0 || LO_STATE != prev) ? 4'd1 : run + 4'd1;
    slips     = quad_idx(tgt_q) - quad_idx(LO_STATE);

    case (state)
      S_IDLE, S_FAILED: begin
        if (START) begin
          capture   = 1'b1;
          div_nxt   = DIV_CFG;
          try_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_END) begin
          cnt_nxt   = '0;
          run_nxt   = '0;
          state_nxt = S_MEAS;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_MEAS: begin
        run_nxt = run_inc;
        if (run_inc == NCONS_L) begin
          meas_nxt = LO_STATE;
          cnt_nxt  = '0;
          if (slips == 2'd0) begin
            loss_nxt  = '0;
            state_nxt = S_LOCKED;
          end else if (try_q == MAX_TRY_L) begin
            state_nxt = S_FAILED;
          end else begin
            try_nxt   = try_q + 3'd1;
            rem_nxt   = slips;
            state_nxt = S_SLIP;
          end
        end else if (cnt == MEAS_END) begin
          cnt_nxt = '0;
          run_nxt = '0;
          if (try_q == MAX_TRY_L) state_nxt = S_FAILED;
          else                    try_nxt   = try_q + 3'd1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_SLIP: begin
        // cnt == 0 is the pulse cycle; the following SLIP_GAP cycles stay low.
        if (cnt == GAP_END) begin
          cnt_nxt = '0;
          if (rem == 2'd1) state_nxt = S_SETTLE;
          else             rem_nxt   = rem - 2'd1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_LOCKED: begin
        if (LO_STATE != tgt_q) begin
          if (loss == LOSS_END) begin
            loss_nxt = '0;
            if (AUTO_RELOCK) begin
              try_nxt   = '0;
              cnt_nxt   = '0;
              run_nxt   = '0;
              state_nxt = S_MEAS;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            loss_nxt = loss + 4'd1;
          end
        end else begin
          loss_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (ABORT && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      run_nxt   = '0;
      loss_nxt  = '0;
      rem_nxt   = '0;
      div_nxt   = lo_div_q;
      try_nxt   = try_q;
      meas_nxt  = meas_q;
      capture   = 1'b0;
    end
  end

  assign LO_DIV     = lo_div_q;
  assign TRY_CNT    = try_q;
  assign MEAS_STATE = meas_q;
  assign SLIP       = (state == S_SLIP) && (cnt == 8'd0);
  assign LOCK       = (state == S_LOCKED);
  assign FAIL       = (state == S_FAILED);
  assign BUSY       = (state == S_SETTLE) || (state == S_MEAS) || (state == S_SLIP);

endmodule

// File: tb/tb_lo_phase_sync_ctrl.sv
// Directed bench for lo_phase_sync_ctrl: lock, slip, timeout/fail, loss-of-lock, abort and reset.
module tb_lo_phase_sync_ctrl;

  logic       REF = 1'b0;
  logic       NRST;
  logic       START, ABORT, AUTO_RELOCK;
  logic [2:0] DIV_CFG;
  logic [1:0] TGT_STATE, lo_set, LO_STATE;
  logic [2:0] LO_DIV, TRY_CNT;
  logic       SLIP, BUSY, LOCK, FAIL;
  logic [1:0] MEAS_STATE;

  logic       toggle_en = 1'b0;
  logic       tog = 1'b0;
  logic       slip_prev = 1'b0;
  int         slip_total = 0;
  int         slip_dbl = 0;
  int         slip_base;
  int         errors = 0;
  int         checks = 0;

  lo_phase_sync_ctrl dut (
    .REF(REF), .NRST(NRST), .START(START), .ABORT(ABORT), .DIV_CFG(DIV_CFG),
    .TGT_STATE(TGT_STATE), .AUTO_RELOCK(AUTO_RELOCK), .LO_STATE(LO_STATE),
    .LO_DIV(LO_DIV), .SLIP(SLIP), .BUSY(BUSY), .LOCK(LOCK), .FAIL(FAIL),
    .TRY_CNT(TRY_CNT), .MEAS_STATE(MEAS_STATE)
  );

  always #5 REF = ~REF;

  // LO quadrant toggling 11/01 every REF cycle, changing away from the sampling edge.
  always @(negedge REF) tog <= ~tog;
  assign LO_STATE = toggle_en ? (tog ? 2'b11 : 2'b01) : lo_set;

  always @(negedge REF) begin
    if (SLIP) slip_total <= slip_total + 1;
    if (SLIP && slip_prev) slip_dbl <= slip_dbl + 1;
    slip_prev <= SLIP;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge REF);
      #1;
    end
  endtask

  initial begin
    NRST = 1'b0; START = 1'b0; ABORT = 1'b0; AUTO_RELOCK = 1'b1;
    DIV_CFG = 3'd0; TGT_STATE = 2'b00; lo_set = 2'b10;
    step(3);
    chk("rst_lo_div", 32'(LO_DIV), 32'd0);
    chk("rst_slip", 32'(SLIP), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_lock", 32'(LOCK), 32'd0);
    chk("rst_fail", 32'(FAIL), 32'd0);
    chk("rst_try", 32'(TRY_CNT), 32'd0);
    chk("rst_meas", 32'(MEAS_STATE), 32'd0);
    NRST = 1'b1;
    step(2);

    // Already aligned: lock after 1 + 8 + 4 cycles with no slips.
    slip_base = slip_total;
    DIV_CFG = 3'd3; TGT_STATE = 2'b10; lo_set = 2'b10; START = 1'b1;
    step(1);
    START = 1'b0;
    chk("t1_lo_div", 32'(LO_DIV), 32'd3);
    chk("t1_busy", 32'(BUSY), 32'd1);
    step(11);
    chk("t1_lock_early", 32'(LOCK), 32'd0);
    step(1);
    chk("t1_lock", 32'(LOCK), 32'd1);
    chk("t1_busy_lk", 32'(BUSY), 32'd0);
    chk("t1_try", 32'(TRY_CNT), 32'd0);
    chk("t1_meas", 32'(MEAS_STATE), 32'h2);
    chk("t1_slips", 32'(slip_total - slip_base), 32'd0);

    // Two mismatches then a match keep lock; three mismatches trigger relock.
    lo_set = 2'b11;
    step(2);
    lo_set = 2'b10;
    step(1);
    chk("t4_hold", 32'(LOCK), 32'd1);
    step(2);
    chk("t4_hold2", 32'(LOCK), 32'd1);
    lo_set = 2'b11;
    step(2);
    chk("t4_lock2", 32'(LOCK), 32'd1);
    step(1);
    chk("t4_lost", 32'(LOCK), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd1);
    chk("t4_try", 32'(TRY_CNT), 32'd0);
    lo_set = 2'b10;
    step(3);
    chk("t4_relock_early", 32'(LOCK), 32'd0);
    step(1);
    chk("t4_relock", 32'(LOCK), 32'd1);
    ABORT = 1'b1;
    step(1);
    ABORT = 1'b0;
    chk("ab_lock", 32'(LOCK), 32'd0);
    chk("ab_busy", 32'(BUSY), 32'd0);
    chk("ab_div_kept", 32'(LO_DIV), 32'd3);

    // LO at 01 (idx 2) against target 10: two slips three cycles apart.
    slip_base = slip_total;
    DIV_CFG = 3'd5; lo_set = 2'b01; START = 1'b1;
    step(1);
    START = 1'b0;
    chk("t2_lo_div", 32'(LO_DIV), 32'd5);
    step(12);
    chk("t2_slip1", 32'(SLIP), 32'd1);
    chk("t2_meas1", 32'(MEAS_STATE), 32'h1);
    chk("t2_try", 32'(TRY_CNT), 32'd1);
    step(1);
    chk("t2_gap", 32'(SLIP), 32'd0);
    step(2);
    chk("t2_slip2", 32'(SLIP), 32'd1);
    lo_set = 2'b10;
    step(1);
    chk("t2_gap2", 32'(SLIP), 32'd0);
    step(13);
    chk("t2_lock_early", 32'(LOCK), 32'd0);
    step(1);
    chk("t2_lock", 32'(LOCK), 32'd1);
    chk("t2_meas2", 32'(MEAS_STATE), 32'h2);
    chk("t2_try_end", 32'(TRY_CNT), 32'd1);
    chk("t2_slips", 32'(slip_total - slip_base), 32'd2);
    ABORT = 1'b1;
    step(1);
    ABORT = 1'b0;

    // LO at 11 (idx 1): three slips planned, abort during the second.
    slip_base = slip_total;
    lo_set = 2'b11; START = 1'b1;
    step(1);
    START = 1'b0;
    step(12);
    chk("t5_slip1", 32'(SLIP), 32'd1);
    step(3);
    chk("t5_slip2", 32'(SLIP), 32'd1);
    ABORT = 1'b1;
    step(1);
    ABORT = 1'b0;
    chk("t5_slip_off", 32'(SLIP), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    step(6);
    chk("t5_slips", 32'(slip_total - slip_base), 32'd2);
    chk("t5_meas_kept", 32'(MEAS_STATE), 32'h3);

    // Toggling LO never gives a valid run: eight 16-cycle windows, then FAILED.
    slip_base = slip_total;
    toggle_en = 1'b1; START = 1'b1;
    step(1);
    START = 1'b0;
    chk("t3_try0", 32'(TRY_CNT), 32'd0);
    step(23);
    chk("t3_try_pre", 32'(TRY_CNT), 32'd0);
    step(1);
    chk("t3_try1", 32'(TRY_CNT), 32'd1);
    step(111);
    chk("t3_fail_early", 32'(FAIL), 32'd0);
    chk("t3_try7", 32'(TRY_CNT), 32'd7);
    step(1);
    chk("t3_fail", 32'(FAIL), 32'd1);
    chk("t3_busy", 32'(BUSY), 32'd0);
    chk("t3_try_end", 32'(TRY_CNT), 32'd7);
    chk("t3_slips", 32'(slip_total - slip_base), 32'd0);
    step(3);
    chk("t3_fail_held", 32'(FAIL), 32'd1);

    // START out of FAILED restarts, then reset asynchronously mid-settle.
    toggle_en = 1'b0; lo_set = 2'b10; DIV_CFG = 3'd1; START = 1'b1;
    step(1);
    START = 1'b0;
    chk("t6_fail_clr", 32'(FAIL), 32'd0);
    chk("t6_busy", 32'(BUSY), 32'd1);
    chk("t6_lo_div", 32'(LO_DIV), 32'd1);
    chk("t6_try", 32'(TRY_CNT), 32'd0);
    step(3);
    #2 NRST = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    chk("t6_rst_div", 32'(LO_DIV), 32'd0);
    chk("t6_rst_meas", 32'(MEAS_STATE), 32'd0);
    chk("t6_rst_slip", 32'(SLIP), 32'd0);
    NRST = 1'b1;
    step(2);
    chk("slip_never_double", 32'(slip_dbl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
